dense_feed_sched: RTL and testbench

DENSE_FEED_SCHED -- requirements
Module: dense_feed_sched

---
 rtl/dense_pkg.sv | 6 +
 rtl/feed_fifo.sv | 40 ++++
 rtl/dense_feed_sched.sv | 115 +++++++++++
 tb/tb_dense_feed_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// dense_pkg: FSM states, beat tags and output FIFO depth shared by the feed scheduler
package dense_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, DRAIN, DONE} state_t;
  typedef enum logic {TAG_B = 1'b0, TAG_A = 1'b1} beat_tag_t;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/feed_fifo.sv
// feed_fifo: small synchronous FIFO holding tagged beats between memory return and datapath
module feed_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 65
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= din;
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/dense_feed_sched.sv
// dense_feed_sched: streams A row pairs and matching B row pairs from two memories to the datapath
module dense_feed_sched
  import dense_pkg::*;
#(
  parameter int N = 560,
  parameter int DW = 32,
  parameter int AW = $clog2(N * N / 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            a_rd_en,
  output logic [AW-1:0]   a_rd_addr,
  input  logic [2*DW-1:0] a_rd_data,
  output logic            b_rd_en,
  output logic [AW-1:0]   b_rd_addr,
  input  logic [2*DW-1:0] b_rd_data,
  output logic [DW-1:0]   datain1,
  output logic [DW-1:0]   datain2,
  output logic            dout_valid,
  output logic            dout_is_a,
  input  logic            dout_ready,
  input  logic            res_valid
);
  localparam int HALF = N / 2;
  localparam int RES_TOTAL = N * N / 2;
  localparam int RW = $clog2(RES_TOTAL + 1);
  localparam int FW = 2 * DW + 1;
  state_t state_q, state_d;
  beat_tag_t ret_tag_q, ret_tag_d;
  logic [AW-1:0] i_q, i_d, kp_q, kp_d, j_q, j_d;
  logic [RW-1:0] res_q, res_d;
  logic busy_q, busy_d, done_q, done_d, ret_v_q, ret_v_d;
  logic credit, push, pop, fifo_empty, last_i, last_k, last_j;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt;
  logic [FW-1:0] ret_word, head, beat;
  // a read may issue only if its data is guaranteed a FIFO slot
  assign credit = 32'(fifo_cnt) + 32'(ret_v_q) < FIFO_DEPTH;
  assign a_rd_en = state_q == ISSUE_A && credit;
  assign b_rd_en = state_q == ISSUE_B && credit;
  assign a_rd_addr = AW'(i_q * HALF + kp_q);
  assign b_rd_addr = AW'(kp_q * N + j_q);
  assign last_i = i_q == AW'(N - 1);
  assign last_k = kp_q == AW'(HALF - 1);
  assign last_j = j_q == AW'(N - 1);
  // returning data bypasses an empty FIFO so the stream has no startup bubble
  assign ret_word = {1'(ret_tag_q), ret_tag_q == TAG_A ? a_rd_data : b_rd_data};
  assign beat = fifo_empty ? ret_word : head;
  assign dout_valid = !fifo_empty || ret_v_q;
  assign pop = !fifo_empty && dout_ready;
  assign push = ret_v_q && !(fifo_empty && dout_ready);
  assign datain1 = dout_valid ? beat[DW-1:0] : '0;
  assign datain2 = dout_valid ? beat[2*DW-1:DW] : '0;
  assign dout_is_a = dout_valid && beat[2*DW];
  assign busy = busy_q;
  assign done = done_q;
  feed_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(ret_word), .pop(pop),
    .dout(head), .count(fifo_cnt), .empty(fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    kp_d = kp_q;
    j_d = j_q;
    res_d = res_q + RW'(state_q != IDLE && res_valid && res_q != RW'(RES_TOTAL));
    case (state_q)
      IDLE: state_d = start ? ISSUE_A : IDLE;
      ISSUE_A: state_d = credit ? ISSUE_B : ISSUE_A;
      ISSUE_B: if (credit) begin
        j_d = last_j ? '0 : j_q + 1'b1;
        if (last_j) begin
          kp_d = last_k ? '0 : kp_q + 1'b1;
          i_d = last_k ? (last_i ? '0 : i_q + 1'b1) : i_q;
          state_d = last_k && last_i ? DRAIN : ISSUE_A;
        end
      end
      DRAIN: state_d = fifo_empty && !ret_v_q && res_q == RW'(RES_TOTAL) ? DONE : DRAIN;
      DONE: begin
        state_d = IDLE;
        res_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == ISSUE_A || state_d == ISSUE_B || state_d == DRAIN;
    done_d = state_d == DONE;
    ret_v_d = a_rd_en || b_rd_en;
    ret_tag_d = a_rd_en ? TAG_A : TAG_B;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ret_tag_q <= TAG_B;
      i_q <= '0;
      kp_q <= '0;
      j_q <= '0;
      res_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ret_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_tag_q <= ret_tag_d;
      i_q <= i_d;
      kp_q <= kp_d;
      j_q <= j_d;
      res_q <= res_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ret_v_q <= ret_v_d;
    end
  end
endmodule

// File: tb/tb_dense_feed_sched.sv
// tb_dense_feed_sched: table-driven and hand-sequenced checks of the feed scheduler at N = 4
module tb_dense_feed_sched;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int AW = $clog2(N * N / 2);
  localparam int W = N / 2;
  localparam int BEATS = N * (N / 2) * (N + 1);
  typedef logic [2*DW:0] beat_t;
  typedef struct {
    string name;
    int mode;
    int n_res;
    bit busy_start;
    int exp_beats;
    int exp_done;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, dout_ready = 1, res_valid = 0;
  logic busy, done, a_rd_en, b_rd_en, dout_valid, dout_is_a;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [2*DW-1:0] a_rd_data = '0, b_rd_data = '0;
  logic [DW-1:0] datain1, datain2;
  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];
  logic [2*DW-1:0] amem [N*N/2];
  logic [2*DW-1:0] bmem [N*N/2];
  beat_t got[$], expq[$], first_run[$];
  int cyc = 0, mode_r = 0, n_chk = 0, n_fail = 0;
  int done_cnt = 0, done_cyc = 0, last_cyc = 0, busy_at_done = 0, stall_err = 0;
  int first_a = -1, first_v = -1;
  bit arm = 0, prev_stall = 0;
  logic [2*DW+1:0] prev_out = '0;

  dense_feed_sched #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .datain1(datain1), .datain2(datain2), .dout_valid(dout_valid),
    .dout_is_a(dout_is_a), .dout_ready(dout_ready), .res_valid(res_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    dout_ready = mode_r == 0 ? 1'b1 : mode_r == 1 ? ~dout_ready : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      got.push_back({dout_is_a, datain2, datain1});
      last_cyc = cyc;
    end
    if (!rst && prev_stall && {dout_valid, dout_is_a, datain2, datain1} !== prev_out) stall_err++;
    prev_stall = !rst && dout_valid && !dout_ready;
    prev_out = {dout_valid, dout_is_a, datain2, datain1};
    if (arm && first_a < 0 && a_rd_en) first_a = cyc;
    if (arm && first_v < 0 && dout_valid) first_v = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) busy_at_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // random matrices, packed two elements per word, and the beat order they imply
  task automatic fill();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        am[r][c] = $urandom;
        bm[r][c] = $urandom;
        amem[r*W + c/2][(c%2)*DW +: DW] = am[r][c];
        bmem[r*W + c/2][(c%2)*DW +: DW] = bm[r][c];
      end
    expq.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k += 2) begin
        expq.push_back({1'b1, am[i][k+1], am[i][k]});
        for (int r = k; r < k + 2; r++)
          for (int c = 0; c < W; c++) expq.push_back({1'b0, bm[r][2*c+1], bm[r][2*c]});
      end
  endtask

  task automatic cmp_seq(input string tag, input beat_t q[$]);
    check({tag, "_beat_count"}, q.size(), expq.size());
    for (int i = 0; i < expq.size() && i < q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), q[i], expq[i]);
  endtask

  task automatic run(input int mode, input int n_res, input bit busy_start, output bit to);
    int sent = 0, t = 0, st, d0;
    got.delete();
    mode_r = mode;
    first_a = -1;
    first_v = -1;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1;
    st = cyc;
    arm = 1;
    @(posedge clk);
    #1 start = 0;
    check("busy_after_start", busy, 1);
    to = 1;
    while (t < 400) begin
      res_valid = t % 3 == 1 && sent < n_res;
      if (res_valid) sent++;
      start = busy_start && t == 5;
      @(negedge clk);
      if (done_cnt != d0) begin
        to = 0;
        break;
      end
      @(posedge clk);
      #1 t++;
    end
    res_valid = 0;
    start = 0;
    arm = 0;
    check("first_a_rd_en_latency", first_a - st, 1);
    check("first_dout_valid_latency", first_v - st, 2);
  endtask

  initial begin
    vec_t tbl[4];
    int d0;
    bit to;
    tbl[0] = '{"ready_high", 0, 8, 1'b0, BEATS, 1};
    tbl[1] = '{"ready_toggle", 1, 8, 1'b0, BEATS, 1};
    tbl[2] = '{"ready_random_res9", 2, 9, 1'b0, BEATS, 1};
    tbl[3] = '{"start_while_busy", 0, 8, 1'b1, BEATS, 1};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, dout_valid, dout_is_a, a_rd_en, b_rd_en,
                            a_rd_addr, b_rd_addr, datain1, datain2}, 0);
    rst = 0;
    cycles(2);
    for (int v = 0; v < 4; v++) begin
      fill();
      d0 = done_cnt;
      run(tbl[v].mode, tbl[v].n_res, tbl[v].busy_start, to);
      mode_r = 0;
      cycles(8);
      check({tbl[v].name, "_done_seen"}, to, 0);
      check({tbl[v].name, "_beats"}, got.size(), tbl[v].exp_beats);
      cmp_seq(tbl[v].name, got);
      check({tbl[v].name, "_done_count"}, done_cnt - d0, tbl[v].exp_done);
      check({tbl[v].name, "_done_after_last_beat"}, done_cyc > last_cyc, 1);
      check({tbl[v].name, "_idle_after"}, busy, 0);
      check({tbl[v].name, "_stall_stability"}, stall_err, 0);
      check({tbl[v].name, "_busy_low_on_done"}, busy_at_done, 0);
    end
    // results seen while idle must not count toward completion
    fill();
    d0 = done_cnt;
    res_valid = 1;
    cycles(2);
    res_valid = 0;
    run(0, 6, 0, to);
    check("idle_res_no_early_done", to, 1);
    check("idle_res_still_busy", busy, 1);
    res_valid = 1;
    cycles(2);
    res_valid = 0;
    for (int t = 0; t < 20 && done_cnt == d0; t++) @(negedge clk);
    check("late_res_done_count", done_cnt - d0, 1);
    cmp_seq("idle_res", got);
    // abandon a run mid-stream, then restart from the top
    fill();
    got.delete();
    mode_r = 0;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int t = 0; t < 200 && got.size() < 17; t++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    check("reset_midrun_outputs", {busy, done, dout_valid, dout_is_a, a_rd_en, b_rd_en,
                                   a_rd_addr, b_rd_addr, datain1, datain2}, 0);
    cycles(3);
    rst = 0;
    cycles(4);
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", {busy, dout_valid}, 0);
    run(0, 8, 0, to);
    cycles(8);
    check("restart_done_seen", to, 0);
    cmp_seq("restart", got);
    // second start issued the cycle after done
    fill();
    run(0, 8, 0, to);
    first_run = got;
    check("b2b_first_done_seen", to, 0);
    run(0, 8, 0, to);
    cycles(8);
    check("b2b_second_done_seen", to, 0);
    cmp_seq("b2b_first", first_run);
    cmp_seq("b2b_second", got);
    check("final_stall_stability", stall_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
